// File: rtl/pagerank_pkg.sv
// pagerank_pkg: shared widths, swap FSM states and the page-owner helper
package pagerank_pkg;
  localparam int M = 64;
  localparam int ID_W = 6;
  localparam int VAL_W = 16;
  localparam int RESP_W = VAL_W + ID_W;
  typedef enum logic {IDLE, DRAIN} swap_state_e;
  function automatic logic [ID_W-1:0] owner_of(input logic [ID_W-1:0] id, input int lg);
    return id >> lg;
  endfunction
endpackage

// File: rtl/query_fifo.sv
// query_fifo: show-ahead sync FIFO (push/din in, pop, dout head, full/empty out), async reset
module query_fifo #(
  parameter int W = 6,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/ant_responder.sv
// ant_responder: NoC page-value responder (query in, {value,id}/err response out, core writes, bank swap)
module ant_responder
  import pagerank_pkg::*;
#(
  parameter int N = 16,
  parameter int WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             ant_id,
  input  logic                   query_valid,
  input  logic [ID_W-1:0]        query_id,
  output logic                   query_ready,
  output logic                   resp_valid,
  output logic [WIDTH+ID_W-1:0]  resp_data,
  output logic                   resp_err,
  input  logic                   resp_ready,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   swap,
  output logic                   swap_pending,
  output logic                   wr_bank
);
  localparam int AW = $clog2(N);
  logic [WIDTH-1:0] bank [2][N];
  logic [WIDTH-1:0] value;
  logic [ID_W-1:0] head;
  logic full, empty, push, pop, owned, drain_done, flip;
  swap_state_e state, state_n;
  assign query_ready = !full && !swap_pending;
  assign push = query_valid && query_ready;
  assign pop = !empty && (!resp_valid || resp_ready);
  assign drain_done = empty && (!resp_valid || resp_ready);
  assign owned = owner_of(head, AW) == ID_W'(ant_id);
  assign value = owned ? bank[~wr_bank][head[AW-1:0]] : '0;
  query_fifo #(.W(ID_W), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(query_id), .pop(pop),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < N; j++) bank[i][j] <= '0;
      wr_bank <= 1'b0;
    end else begin
      if (wr_en) bank[wr_bank][wr_addr] <= wr_data;
      if (flip) wr_bank <= ~wr_bank;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else if (!resp_valid || resp_ready) begin
      resp_valid <= !empty;
      if (!empty) begin
        resp_data <= {value, head};
        resp_err <= !owned;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb state_n = (state == IDLE) ? (swap ? DRAIN : IDLE) : (drain_done ? IDLE : DRAIN);
  always_comb begin
    swap_pending = state == DRAIN;
    flip = (state == DRAIN) && drain_done;
  end
endmodule

// File: tb/tb_ant_responder.sv
// tb_ant_responder: directed self-checking bench for ant_responder
module tb_ant_responder;
  logic clk = 0, reset = 1;
  logic [1:0] ant_id = 2'd1;
  logic query_valid = 0, query_ready, resp_valid, resp_err, resp_ready = 1;
  logic [5:0] query_id = 0;
  logic [21:0] resp_data;
  logic wr_en = 0, swap = 0, swap_pending, wr_bank;
  logic [3:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  int tests = 0, fails = 0;
  ant_responder dut (
    .clk(clk), .reset(reset), .ant_id(ant_id), .query_valid(query_valid), .query_id(query_id),
    .query_ready(query_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ready(resp_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .swap(swap),
    .swap_pending(swap_pending), .wr_bank(wr_bank)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [5:0] id);
    query_valid = 1;
    query_id = id;
    cyc();
    query_valid = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    cyc();
    cyc();
    tests++; if (query_ready !== 1'b1) begin fails++; $display("FAIL rst_qready got %b exp 1", query_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_rvalid got %b exp 0", resp_valid); end
    tests++; if (resp_data !== 22'h0) begin fails++; $display("FAIL rst_rdata got %h exp 0", resp_data); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL rst_rerr got %b exp 0", resp_err); end
    tests++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL rst_pend got %b exp 0", swap_pending); end
    tests++; if (wr_bank !== 1'b0) begin fails++; $display("FAIL rst_bank got %b exp 0", wr_bank); end
    reset = 0;
    cyc();
  endtask
  task automatic test_lookup_after_swap();
    wr_en = 1; wr_addr = 4'd3; wr_data = 16'h1234;
    cyc();
    wr_en = 0; swap = 1;
    cyc();
    swap = 0;
    tests++; if (swap_pending !== 1'b1) begin fails++; $display("FAIL swap_pend got %b exp 1", swap_pending); end
    tests++; if (query_ready !== 1'b0) begin fails++; $display("FAIL swap_qready got %b exp 0", query_ready); end
    tests++; if (wr_bank !== 1'b0) begin fails++; $display("FAIL swap_bank_early got %b exp 0", wr_bank); end
    cyc();
    tests++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL swap_done got %b exp 0", swap_pending); end
    tests++; if (wr_bank !== 1'b1) begin fails++; $display("FAIL swap_bank got %b exp 1", wr_bank); end
    tests++; if (query_ready !== 1'b1) begin fails++; $display("FAIL look_qready got %b exp 1", query_ready); end
    issue(6'd19);
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL look_t1 got %b exp 0", resp_valid); end
    cyc();
    tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL look_t2 got %b exp 1", resp_valid); end
    tests++; if (resp_data !== {16'h1234, 6'd19}) begin fails++; $display("FAIL look_data got %h exp %h", resp_data, {16'h1234, 6'd19}); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL look_err got %b exp 0", resp_err); end
    cyc();
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL look_drain got %b exp 0", resp_valid); end
  endtask
  task automatic test_unowned();
    issue(6'd5);
    cyc();
    tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL unown_valid got %b exp 1", resp_valid); end
    tests++; if (resp_data !== {16'h0000, 6'd5}) begin fails++; $display("FAIL unown_data got %h exp %h", resp_data, {16'h0000, 6'd5}); end
    tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL unown_err got %b exp 1", resp_err); end
    cyc();
  endtask
  task automatic test_backpressure();
    logic [21:0] exp [5];
    int acc = 0;
    exp[0] = {16'h0000, 6'd16}; exp[1] = {16'h0000, 6'd17}; exp[2] = {16'h0000, 6'd18};
    exp[3] = {16'h1234, 6'd19}; exp[4] = {16'h0000, 6'd20};
    resp_ready = 0;
    for (int i = 0; i < 6; i++) begin
      query_valid = 1;
      query_id = 6'(16 + i);
      if (query_ready) acc++;
      cyc();
    end
    query_valid = 0;
    tests++; if (acc !== 5) begin fails++; $display("FAIL bp_accepted got %0d exp 5", acc); end
    tests++; if (query_ready !== 1'b0) begin fails++; $display("FAIL bp_qready got %b exp 0", query_ready); end
    for (int i = 0; i < 2; i++) begin
      tests++; if (resp_valid !== 1'b1 || resp_data !== exp[0]) begin fails++; $display("FAIL bp_stall%0d got %b/%h exp 1/%h", i, resp_valid, resp_data, exp[0]); end
      cyc();
    end
    resp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      tests++; if (resp_valid !== 1'b1 || resp_data !== exp[k]) begin fails++; $display("FAIL bp_resp%0d got %b/%h exp 1/%h", k, resp_valid, resp_data, exp[k]); end
      if (k == 1) begin
        tests++; if (query_ready !== 1'b1) begin fails++; $display("FAIL bp_reopen got %b exp 1", query_ready); end
      end
      cyc();
    end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL bp_end got %b exp 0", resp_valid); end
  endtask
  task automatic test_swap_drain();
    resp_ready = 0;
    issue(6'd16);
    issue(6'd19);
    issue(6'd17);
    wr_en = 1; wr_addr = 4'd0; wr_data = 16'hAAAA; swap = 1;
    cyc();
    wr_en = 0;
    tests++; if (swap_pending !== 1'b1) begin fails++; $display("FAIL dr_pend got %b exp 1", swap_pending); end
    tests++; if (query_ready !== 1'b0) begin fails++; $display("FAIL dr_qready got %b exp 0", query_ready); end
    tests++; if (wr_bank !== 1'b1) begin fails++; $display("FAIL dr_bank0 got %b exp 1", wr_bank); end
    resp_ready = 1;
    tests++; if (resp_data !== {16'h0000, 6'd16}) begin fails++; $display("FAIL dr_resp0 got %h exp %h", resp_data, {16'h0000, 6'd16}); end
    cyc();
    swap = 0;
    tests++; if (resp_data !== {16'h1234, 6'd19}) begin fails++; $display("FAIL dr_resp1 got %h exp %h", resp_data, {16'h1234, 6'd19}); end
    cyc();
    tests++; if (resp_valid !== 1'b1 || resp_data !== {16'h0000, 6'd17}) begin fails++; $display("FAIL dr_resp2 got %b/%h exp 1/%h", resp_valid, resp_data, {16'h0000, 6'd17}); end
    tests++; if (wr_bank !== 1'b1) begin fails++; $display("FAIL dr_bank1 got %b exp 1", wr_bank); end
    cyc();
    tests++; if (wr_bank !== 1'b0) begin fails++; $display("FAIL dr_flip got %b exp 0", wr_bank); end
    tests++; if (swap_pending !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL dr_idle got %b/%b exp 0/0", swap_pending, resp_valid); end
    cyc();
    tests++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL dr_noqueue got %b exp 0", swap_pending); end
    issue(6'd16);
    cyc();
    tests++; if (resp_data !== {16'hAAAA, 6'd16}) begin fails++; $display("FAIL dr_newbank got %h exp %h", resp_data, {16'hAAAA, 6'd16}); end
    cyc();
  endtask
  task automatic test_same_edge_write();
    swap = 1;
    cyc();
    swap = 0;
    wr_en = 1; wr_addr = 4'd5; wr_data = 16'h5A5A;
    tests++; if (swap_pending !== 1'b1) begin fails++; $display("FAIL se_pend got %b exp 1", swap_pending); end
    cyc();
    wr_en = 0;
    tests++; if (wr_bank !== 1'b1) begin fails++; $display("FAIL se_bank got %b exp 1", wr_bank); end
    issue(6'd21);
    cyc();
    tests++; if (resp_valid !== 1'b1 || resp_data !== {16'h5A5A, 6'd21}) begin fails++; $display("FAIL se_data got %b/%h exp 1/%h", resp_valid, resp_data, {16'h5A5A, 6'd21}); end
    cyc();
  endtask
  task automatic test_reset_mid();
    resp_ready = 0;
    issue(6'd20);
    issue(6'd21);
    swap = 1;
    cyc();
    swap = 0;
    tests++; if (swap_pending !== 1'b1 || resp_valid !== 1'b1) begin fails++; $display("FAIL rm_setup got %b/%b exp 1/1", swap_pending, resp_valid); end
    #2 reset = 1;
    #1;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rm_rvalid got %b exp 0", resp_valid); end
    tests++; if (resp_data !== 22'h0 || resp_err !== 1'b0) begin fails++; $display("FAIL rm_rdata got %h/%b exp 0/0", resp_data, resp_err); end
    tests++; if (swap_pending !== 1'b0 || wr_bank !== 1'b0) begin fails++; $display("FAIL rm_swap got %b/%b exp 0/0", swap_pending, wr_bank); end
    tests++; if (query_ready !== 1'b1) begin fails++; $display("FAIL rm_qready got %b exp 1", query_ready); end
    cyc();
    reset = 0;
    resp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rm_stale%0d got %b exp 0", i, resp_valid); end
    end
    issue(6'd16);
    cyc();
    tests++; if (resp_valid !== 1'b1 || resp_data !== {16'h0000, 6'd16}) begin fails++; $display("FAIL rm_bank got %b/%h exp 1/%h", resp_valid, resp_data, {16'h0000, 6'd16}); end
    cyc();
  endtask
  initial begin
    test_reset();
    test_lookup_after_swap();
    test_unowned();
    test_backpressure();
    test_swap_drain();
    test_same_edge_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
